dsm_multi: RTL and testbench
============================

Name: dsm_multi

Overview:
Parametrised multi-channel delta-sigma DAC modulator, next generation of the single-channel 1st-order DSM in the audio output path. It pulls one interleaved multi-channel frame from the sample FIFO every OSR clocks. Per channel it runs a selectable 1st- or 2nd-order loop with saturating integrators and drives one 1-bit output per channel. It adds underrun handling with a sticky flag, and a mute input.

Parameters:
W, 16, sample width (signed two's complement), 8..24
NCH, 2, channel count, 1..8
OSR, 128, clocks per frame (power of 2, >=8)
HOLD_ON_UNDERRUN, 1, 1 = hold last sample on underrun; 0 = substitute zero

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
data_in  in  NCH*W  FIFO read data; channel k at bits [k*W+W-1 : k*W]; valid one cycle after an accepted rdreq
empty  in  1  FIFO empty
rdreq  out  1  FIFO read request, one pulse per frame
order_sel  in  1  0 = 1st order, 1 = 2nd order
mute  in  1  forces loaded samples to zero
clr_underrun  in  1  clears the underrun flag
outsignal  out  NCH  1-bit modulated output per channel
underrun  out  1  sticky flag: a frame fetch found the FIFO empty

Behaviour:
- Clock and reset: single clk domain. Reset is asynchronous and active-low. While reset_n=0:
  - cnt, all integrators, sample registers, rdreq_r, rd_taken, outsignal and underrun are 0.
  - The order_reg is 0.
  - Reset asserted mid-frame aborts the frame immediately; no pending read completes.
- Frame counter: cnt is log2(OSR) bits, increments every clock and wraps OSR-1 -> 0.
- Fetch handshake:
  - rdreq_r is registered high only during the cnt==1 cycle.
  - rdreq = rdreq_r & ~empty, combinational gate, so rdreq never asserts while empty=1.
  - rd_taken registers rdreq.
  - In the cnt==2 cycle, if rd_taken=1, sample[k] <= mute ? 0 : data_in channel k.
- Underrun: if empty=1 during the cnt==1 cycle, no read occurs and underrun sets.
  - At cnt==2 the sample is held (HOLD_ON_UNDERRUN=1) or loaded with 0 (=0).
  - If mute=1, the sample is loaded with 0 in either case.
  - clr_underrun clears the flag. If a set and a clear occur in the same cycle, set wins.
- Mute: applied only at the load point (cnt==2). Muted channels converge to a 50% duty idle pattern.
- Order switch:
  - order_sel is sampled into order_reg at cnt==0.
  - If the sampled value differs from order_reg, all integrators clear that same cycle.
  - There is no mid-frame order change.
- Loop arithmetic, per channel, every clock:
  - x = sample (sign-extended). FS = 2^(W-1)-1. fb = outsignal[k] ? +FS : -FS.
  - 1st order: acc1 <= sat(acc1 + x - fb). outsignal[k] <= (next acc1 >= 0).
  - 2nd order: acc1 <= sat(acc1 + x - fb); acc2 <= sat(acc2 + acc1_next - 2*fb). outsignal[k] <= (next acc2 >= 0).
  - Widths: acc1 is W+2 bits, acc2 is W+4 bits. sat() clamps to the signed range of the destination; it never wraps.
  - Unused acc2 is held at 0 in 1st-order mode.
- Output: outsignal is registered and changes only on the clk edge. Loop latency from sample load to its first effect on outsignal is 1 clock.
- Ones density: steady-state density = (1 + x/FS)/2 ±1/OSR, averaged over >=16 frames.
- Channels are fully independent apart from the shared cnt and rdreq.

Test Plan:
1. Reset (W=16, NCH=2, OSR=128): hold reset_n=0 with empty=0 -> rdreq, outsignal=2'b00 and underrun all 0; release -> first rdreq pulse at cnt==1, exactly 1 cycle wide, then every 128 clocks.
2. DC, order 1: FIFO supplies ch0=16'h4000, ch1=16'hC000 -> over 2048 clocks ch0 ones count 1536±16, ch1 ones count 512±16.
3. DC, order 2 (order_sel=1 before frame): ch0=16'h7000 for 32 frames -> ones density 0.9375±1/128, integrators never reach saturation limits; switching order_sel at mid-frame takes effect only at next cnt==0 with integrators cleared.
4. Underrun: empty=1 across the cnt==1 cycle -> rdreq stays 0, underrun=1 from next clock, sample held (HOLD=1) or 0 (HOLD=0); clr_underrun pulse -> flag 0; set+clear in the same cycle -> flag 1.
5. Mute: mute=1 with input 16'h7FFF -> sample loaded 0, density converges to 50%±1/128 within 4 frames.
6. Async reset mid-frame: drop reset_n at cnt==1 with rdreq high -> rdreq, outsignal, cnt and integrators 0 immediately without a clock edge; no read is counted after release.

Source files
------------

// File: rtl/dsm_multi.sv
// dsm_multi: multi-channel delta-sigma DAC modulator.
// Every OSR clocks one interleaved frame (NCH samples of W bits) is pulled from
// the sample FIFO. Each channel runs a 1st- or 2nd-order loop with saturating
// integrators and drives one 1-bit output. FIFO underruns raise a sticky flag,
// and mute forces the loaded samples to zero.
module dsm_multi #(
  parameter int W                = 16,
  parameter int NCH              = 2,
  parameter int OSR              = 128,
  parameter int HOLD_ON_UNDERRUN = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [NCH*W-1:0] data_in,
  input  logic             empty,
  output logic             rdreq,
  input  logic             order_sel,
  input  logic             mute,
  input  logic             clr_underrun,
  output logic [NCH-1:0]   outsignal,
  output logic             underrun
);

  localparam int CW  = $clog2(OSR);
  localparam int A1W = W + 2;   // first integrator width
  localparam int A2W = W + 4;   // second integrator width
  localparam int SW  = W + 6;   // headroom for the unsaturated sums

  // Frame phases: order sampled at 0, fetch request visible at 1, load at 2.
  localparam logic [CW-1:0] CNT_ORDER = CW'(0);
  localparam logic [CW-1:0] CNT_LOAD  = CW'(2);
  localparam logic [CW-1:0] CNT_LAST  = CW'(OSR - 1);

  localparam logic signed [SW-1:0] FS_S     = SW'((64'sd1 <<< (W - 1)) - 64'sd1);
  localparam logic signed [SW-1:0] A1_MAX_S = SW'((64'sd1 <<< (A1W - 1)) - 64'sd1);
  localparam logic signed [SW-1:0] A1_MIN_S = SW'(-(64'sd1 <<< (A1W - 1)));
  localparam logic signed [SW-1:0] A2_MAX_S = SW'((64'sd1 <<< (A2W - 1)) - 64'sd1);
  localparam logic signed [SW-1:0] A2_MIN_S = SW'(-(64'sd1 <<< (A2W - 1)));

  // Clamp a wide sum into the first integrator range.
  function automatic logic signed [A1W-1:0] sat_acc1(input logic signed [SW-1:0] v);
    logic signed [A1W-1:0] r;
    if (v > A1_MAX_S) begin
      r = A1_MAX_S[A1W-1:0];
    end else if (v < A1_MIN_S) begin
      r = A1_MIN_S[A1W-1:0];
    end else begin
      r = v[A1W-1:0];
    end
    return r;
  endfunction

  // Clamp a wide sum into the second integrator range.
  function automatic logic signed [A2W-1:0] sat_acc2(input logic signed [SW-1:0] v);
    logic signed [A2W-1:0] r;
    if (v > A2_MAX_S) begin
      r = A2_MAX_S[A2W-1:0];
    end else if (v < A2_MIN_S) begin
      r = A2_MIN_S[A2W-1:0];
    end else begin
      r = v[A2W-1:0];
    end
    return r;
  endfunction

  logic [CW-1:0]          cnt_r;
  logic                   rdreq_r;
  logic                   rd_taken_r;
  logic                   underrun_r;
  logic                   order_r;
  logic                   order_chg_s;
  logic [NCH-1:0]         out_r;
  logic [NCH-1:0]         out_nxt_s;
  logic signed [W-1:0]    sample_r   [NCH];
  logic signed [A1W-1:0]  acc1_r     [NCH];
  logic signed [A2W-1:0]  acc2_r     [NCH];
  logic signed [A1W-1:0]  acc1_nxt_s [NCH];
  logic signed [A2W-1:0]  acc2_nxt_s [NCH];
  logic signed [SW-1:0]   x_s        [NCH];
  logic signed [SW-1:0]   fb_s       [NCH];
  logic signed [SW-1:0]   sum1_s     [NCH];
  logic signed [SW-1:0]   sum2_s     [NCH];

  // The request is gated by empty so the FIFO is never read while empty.
  assign rdreq       = rdreq_r & ~empty;
  assign outsignal   = out_r;
  assign underrun    = underrun_r;
  assign order_chg_s = (cnt_r == CNT_ORDER) && (order_sel != order_r);

  // Free-running frame counter, wraps at OSR-1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r <= '0;
    end else if (cnt_r == CNT_LAST) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

  // Fetch handshake: request during the cnt==1 cycle, remember if it was taken.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdreq_r    <= 1'b0;
      rd_taken_r <= 1'b0;
    end else begin
      rdreq_r    <= (cnt_r == CNT_ORDER);
      rd_taken_r <= rdreq;
    end
  end

  // Sticky underrun flag; a new underrun beats a simultaneous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      underrun_r <= 1'b0;
    end else if (rdreq_r && empty) begin
      underrun_r <= 1'b1;
    end else if (clr_underrun) begin
      underrun_r <= 1'b0;
    end else begin
      underrun_r <= underrun_r;
    end
  end

  // Loop order is latched once per frame so it never changes mid-frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      order_r <= 1'b0;
    end else if (cnt_r == CNT_ORDER) begin
      order_r <= order_sel;
    end else begin
      order_r <= order_r;
    end
  end

  // Sample load at cnt==2: fresh data, zero on mute, hold or zero on underrun.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NCH; k++) begin
        sample_r[k] <= '0;
      end
    end else if (cnt_r == CNT_LOAD) begin
      for (int k = 0; k < NCH; k++) begin
        if (mute) begin
          sample_r[k] <= '0;
        end else if (rd_taken_r) begin
          sample_r[k] <= data_in[k*W +: W];
        end else if (HOLD_ON_UNDERRUN != 0) begin
          sample_r[k] <= sample_r[k];
        end else begin
          sample_r[k] <= '0;
        end
      end
    end else begin
      for (int k = 0; k < NCH; k++) begin
        sample_r[k] <= sample_r[k];
      end
    end
  end

  // Per-channel loop arithmetic: integrate error against +/-FS feedback and quantise.
  always_comb begin
    out_nxt_s = '0;
    for (int k = 0; k < NCH; k++) begin
      x_s[k]        = SW'(sample_r[k]);
      fb_s[k]       = out_r[k] ? FS_S : -FS_S;
      sum1_s[k]     = SW'(acc1_r[k]) + x_s[k] - fb_s[k];
      acc1_nxt_s[k] = sat_acc1(sum1_s[k]);
      sum2_s[k]     = SW'(acc2_r[k]) + SW'(acc1_nxt_s[k]) - (fb_s[k] <<< 1);
      if (order_r) begin
        acc2_nxt_s[k] = sat_acc2(sum2_s[k]);
        out_nxt_s[k]  = ~acc2_nxt_s[k][A2W-1];
      end else begin
        acc2_nxt_s[k] = '0;
        out_nxt_s[k]  = ~acc1_nxt_s[k][A1W-1];
      end
    end
  end

  // Loop state update; an order change restarts every channel from a clean state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_r <= '0;
      for (int k = 0; k < NCH; k++) begin
        acc1_r[k] <= '0;
        acc2_r[k] <= '0;
      end
    end else if (order_chg_s) begin
      out_r <= '0;
      for (int k = 0; k < NCH; k++) begin
        acc1_r[k] <= '0;
        acc2_r[k] <= '0;
      end
    end else begin
      out_r <= out_nxt_s;
      for (int k = 0; k < NCH; k++) begin
        acc1_r[k] <= acc1_nxt_s[k];
        acc2_r[k] <= acc2_nxt_s[k];
      end
    end
  end

endmodule

// File: tb/tb_dsm_multi.sv
// Testbench for dsm_multi: directed steps plus a randomised stretch, checked
// against a cycle-level arithmetic reference model and density targets.
module tb_dsm_multi;

  localparam int W    = 16;
  localparam int NCH  = 2;
  localparam int OSR  = 128;
  localparam int HOLD = 1;

  localparam longint FS    = (64'sd1 <<< (W - 1)) - 64'sd1;
  localparam longint A1MAX = (64'sd1 <<< (W + 1)) - 64'sd1;
  localparam longint A1MIN = -(64'sd1 <<< (W + 1));
  localparam longint A2MAX = (64'sd1 <<< (W + 3)) - 64'sd1;
  localparam longint A2MIN = -(64'sd1 <<< (W + 3));

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [NCH*W-1:0] data_in = '0;
  logic             empty = 1'b0;
  logic             order_sel = 1'b0;
  logic             mute = 1'b0;
  logic             clr_underrun = 1'b0;
  logic             rdreq;
  logic [NCH-1:0]   outsignal;
  logic             underrun;

  dsm_multi #(.W(W), .NCH(NCH), .OSR(OSR), .HOLD_ON_UNDERRUN(HOLD)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .data_in      (data_in),
    .empty        (empty),
    .rdreq        (rdreq),
    .order_sel    (order_sel),
    .mute         (mute),
    .clr_underrun (clr_underrun),
    .outsignal    (outsignal),
    .underrun     (underrun)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model state
  int             m_cnt;
  logic           m_taken, m_under, m_order;
  logic [NCH-1:0] m_out;
  longint         m_sample [NCH];
  longint         m_acc1   [NCH];
  longint         m_acc2   [NCH];

  int  trace_bad;
  int  ones [NCH];
  bit  counting;
  int  tick_no;
  int  rd_n;
  int  rd_pos [3];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input longint obs, input longint lo, input longint hi);
    total++;
    assert (obs >= lo && obs <= hi) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  function automatic longint clamp(input longint v, input longint lo, input longint hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic longint chan(input logic [NCH*W-1:0] d, input int k);
    logic signed [W-1:0] t;
    t = d[k*W +: W];
    return longint'(t);
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_taken = 1'b0; m_under = 1'b0; m_order = 1'b0; m_out = '0;
    for (int k = 0; k < NCH; k++) begin
      m_sample[k] = 0; m_acc1[k] = 0; m_acc2[k] = 0;
    end
  endtask

  // advance the model by one clock using the inputs currently applied
  task automatic model_step();
    longint fb, a1, a2;
    bit chg;
    chg = (m_cnt == 0) && (order_sel != m_order);
    for (int k = 0; k < NCH; k++) begin
      if (chg) begin
        m_acc1[k] = 0; m_acc2[k] = 0; m_out[k] = 1'b0;
      end else begin
        fb = m_out[k] ? FS : -FS;
        a1 = clamp(m_acc1[k] + m_sample[k] - fb, A1MIN, A1MAX);
        if (m_order) begin
          a2 = clamp(m_acc2[k] + a1 - 2 * fb, A2MIN, A2MAX);
          m_out[k] = (a2 >= 0);
        end else begin
          a2 = 0;
          m_out[k] = (a1 >= 0);
        end
        m_acc1[k] = a1; m_acc2[k] = a2;
      end
    end
    if (m_cnt == 2) begin
      for (int k = 0; k < NCH; k++) begin
        if (mute) m_sample[k] = 0;
        else if (m_taken) m_sample[k] = chan(data_in, k);
        else if (HOLD == 0) m_sample[k] = 0;
      end
    end
    if (m_cnt == 1 && empty) m_under = 1'b1;
    else if (clr_underrun) m_under = 1'b0;
    m_taken = (m_cnt == 1) && !empty;
    if (m_cnt == 0) m_order = order_sel;
    m_cnt = (m_cnt + 1) % OSR;
  endtask

  task automatic tick();
    logic exp_rd;
    model_step();
    @(posedge clk);
    #1;
    exp_rd = (m_cnt == 1) && !empty;
    if (outsignal !== m_out || underrun !== m_under || rdreq !== exp_rd) trace_bad++;
    if (counting) for (int k = 0; k < NCH; k++) ones[k] += int'(outsignal[k]);
    tick_no++;
    if (rdreq === 1'b1) begin
      if (rd_n < 3) rd_pos[rd_n] = tick_no;
      rd_n++;
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_cnt(input int c);
    for (int i = 0; i < OSR && m_cnt != c; i++) tick();
  endtask

  task automatic count_ones(input int n);
    for (int k = 0; k < NCH; k++) ones[k] = 0;
    counting = 1'b1;
    ticks(n);
    counting = 1'b0;
  endtask

  task automatic trace_check(input string tag);
    check(tag, trace_bad, 0);
    trace_bad = 0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    model_reset();
    trace_bad = 0; counting = 1'b0; tick_no = 0; rd_n = 0;
    for (int i = 0; i < 3; i++) rd_pos[i] = 0;

    // 1. reset state and rdreq cadence
    data_in = {16'hC000, 16'h4000};
    #23;
    check("rst_rdreq", rdreq, 0);
    check("rst_out", outsignal, 0);
    check("rst_underrun", underrun, 0);
    #7;
    reset_n = 1'b1;
    ticks(300);
    check("rd_pulses", rd_n, 3);
    check("rd_first", rd_pos[0], 1);
    check("rd_second", rd_pos[1], 129);
    check("rd_third", rd_pos[2], 257);
    trace_check("trace_reset");

    // 2. DC, first order
    count_ones(2048);
    check_range("dens1_ch0", ones[0], 1520, 1552);
    check_range("dens1_ch1", ones[1], 496, 528);
    trace_check("trace_order1");

    // 3. DC, second order, then a mid-frame order switch
    order_sel = 1'b1;
    data_in = {16'h0000, 16'h7000};
    ticks(8 * OSR);
    count_ones(32 * OSR);
    check_range("dens2_ch0", ones[0], 3808, 3872);
    check_range("dens2_ch1", ones[1], 2016, 2080);
    wait_cnt(64);
    order_sel = 1'b0;
    wait_cnt(0);
    tick();
    check("order_clear_out", outsignal, 2'b00);
    tick();
    check("order_restart_out", outsignal, 2'b11);
    trace_check("trace_order2");

    // 4. underrun: hold, clear, set beats clear
    data_in = {16'hE000, 16'h2000};
    wait_cnt(3);
    wait_cnt(1);
    empty = 1'b1;
    data_in = {16'h1234, 16'h5678};
    #1;
    check("rdreq_gated", rdreq, 0);
    tick();
    check("underrun_set", underrun, 1);
    empty = 1'b0;
    ticks(2 * OSR);
    clr_underrun = 1'b1;
    tick();
    clr_underrun = 1'b0;
    check("underrun_clr", underrun, 0);
    wait_cnt(1);
    empty = 1'b1;
    clr_underrun = 1'b1;
    tick();
    check("underrun_set_wins", underrun, 1);
    empty = 1'b0;
    clr_underrun = 1'b0;
    ticks(OSR);
    trace_check("trace_underrun");

    // 5. mute
    data_in = {16'h7FFF, 16'h7FFF};
    mute = 1'b1;
    ticks(4 * OSR);
    count_ones(8 * OSR);
    check_range("mute_ch0", ones[0], 504, 520);
    check_range("mute_ch1", ones[1], 504, 520);
    trace_check("trace_mute");

    // 6. asynchronous reset in the fetch cycle
    mute = 1'b0;
    data_in = {16'h3000, 16'h3000};
    wait_cnt(1);
    check("rdreq_before_abort", rdreq, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("abort_rdreq", rdreq, 0);
    check("abort_out", outsignal, 0);
    check("abort_underrun", underrun, 0);
    #1;
    reset_n = 1'b1;
    model_reset();
    #1;
    check("release_rdreq", rdreq, 0);
    tick();
    check("release_first_rd", rdreq, 1);
    ticks(3 * OSR);
    trace_check("trace_abort");

    // 7. randomised stretch
    for (int f = 0; f < 16; f++) begin
      mute = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < OSR; i++) begin
        for (int k = 0; k < NCH; k++) data_in[k*W +: W] = W'($urandom);
        empty = ($urandom_range(0, 7) == 0);
        clr_underrun = ($urandom_range(0, 15) == 0);
        if (i == int'($urandom_range(0, OSR - 1))) order_sel = ~order_sel;
        tick();
      end
    end
    empty = 1'b0;
    clr_underrun = 1'b0;
    trace_check("trace_random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
